// File: rtl/countdown_sec_timer.sv
// Two-digit BCD countdown driven by one-second ticks.
// Requests ticks only while running; flags warning and expiry.
module countdown_sec_timer #(
  parameter int unsigned WARN_SECS    = 10,
  parameter logic [3:0]  DEFAULT_TENS = 4'd6,
  parameter logic [3:0]  DEFAULT_ONES = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       one_sec_tick,
  output logic       tick_en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       warn,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] tens_nx;
  logic [3:0] ones_nx;
  logic [3:0] tens_dec;
  logic [3:0] ones_dec;
  logic       dec_zero;
  logic       cnt_zero;
  logic       exp_nx;
  logic [6:0] secs_nx;
  logic       warn_nx;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign cnt_zero = (tens == 4'd0) && (ones == 4'd0);

  // BCD decrement with borrow; 00 never wraps.
  always_comb begin
    tens_dec = tens;
    ones_dec = ones;
    if (ones != 4'd0) begin
      ones_dec = ones - 4'd1;
    end else if (tens != 4'd0) begin
      ones_dec = 4'd9;
      tens_dec = tens - 4'd1;
    end
    dec_zero = (tens_dec == 4'd0) && (ones_dec == 4'd0);
  end

  // Next state and digits; load beats pause beats start beats tick.
  always_comb begin
    state_nx = state;
    tens_nx  = tens;
    ones_nx  = ones;
    exp_nx   = 1'b0;
    if (load) begin
      tens_nx  = clamp9(load_val[7:4]);
      ones_nx  = clamp9(load_val[3:0]);
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cnt_zero) begin
              state_nx = EXPIRED;
              exp_nx   = 1'b1;
            end else begin
              state_nx = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_nx = PAUSE;
          end else if (one_sec_tick) begin
            tens_nx = tens_dec;
            ones_nx = ones_dec;
            if (dec_zero) begin
              state_nx = EXPIRED;
              exp_nx   = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start) begin
            state_nx = RUN;
          end
        end
        EXPIRED: begin
          state_nx = EXPIRED;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Warning window check on the value about to be registered.
  always_comb begin
    secs_nx = ({3'b000, tens_nx} * 7'd10) + {3'b000, ones_nx};
    warn_nx = (secs_nx != 7'd0)
            && (32'(secs_nx) <= WARN_SECS)
            && (state_nx != EXPIRED);
  end

  // State, digits and all outputs are registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tens    <= DEFAULT_TENS;
      ones    <= DEFAULT_ONES;
      tick_en <= 1'b0;
      running <= 1'b0;
      warn    <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      tens    <= tens_nx;
      ones    <= ones_nx;
      tick_en <= (state_nx == RUN);
      running <= (state_nx == RUN);
      warn    <= warn_nx;
      expired <= exp_nx;
      done    <= (state_nx == EXPIRED);
    end
  end

endmodule

// File: tb/tb_countdown_sec_timer.sv
// Directed bench for countdown_sec_timer.
// Each task drives one scenario and checks inline.
module tb_countdown_sec_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       one_sec_tick = 1'b0;
  logic       tick_en;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       warn;
  logic       expired;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_sec_timer #(
    .WARN_SECS(10),
    .DEFAULT_TENS(4'd6),
    .DEFAULT_ONES(4'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .start(start),
    .pause(pause),
    .one_sec_tick(one_sec_tick),
    .tick_en(tick_en),
    .tens(tens),
    .ones(ones),
    .running(running),
    .warn(warn),
    .expired(expired),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    step();
    pause = 1'b0;
  endtask

  task automatic do_tick();
    one_sec_tick = 1'b1;
    step();
    one_sec_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++;
    if ({tens, ones} !== 8'h60) begin
      n_fail++;
      $display("FAIL reset_digits got %h want 60", {tens, ones});
    end
    n_checks++;
    if ({tick_en, running, warn, expired, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000",
               {tick_en, running, warn, expired, done});
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_countdown();
    logic [7:0] want;
    int v;
    do_load(8'h15);
    n_checks++;
    if ({tens, ones} !== 8'h15 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_load got %h run=%b want 15 run=0",
               {tens, ones}, running);
    end
    do_start();
    n_checks++;
    if (running !== 1'b1 || tick_en !== 1'b1) begin
      n_fail++;
      $display("FAIL cd_start got run=%b te=%b want 1 1",
               running, tick_en);
    end
    for (int i = 1; i <= 15; i++) begin
      idle(19);
      do_tick();
      v = 15 - i;
      want = {4'(v / 10), 4'(v % 10)};
      n_checks++;
      if ({tens, ones} !== want) begin
        n_fail++;
        $display("FAIL cd_digits tick %0d got %h want %h",
                 i, {tens, ones}, want);
      end
      n_checks++;
      if (warn !== (v <= 10 && v > 0)) begin
        n_fail++;
        $display("FAIL cd_warn at %0d got %b want %b",
                 v, warn, (v <= 10 && v > 0));
      end
      n_checks++;
      if (expired !== (v == 0)) begin
        n_fail++;
        $display("FAIL cd_expired at %0d got %b want %b",
                 v, expired, (v == 0));
      end
    end
    n_checks++;
    if ({done, tick_en, running} !== 3'b100) begin
      n_fail++;
      $display("FAIL cd_end got d/te/r=%b want 100",
               {done, tick_en, running});
    end
    step();
    n_checks++;
    if (expired !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL cd_pulse_width got exp=%b done=%b want 0 1",
               expired, done);
    end
    do_tick();
    do_start();
    do_pause();
    n_checks++;
    if ({tens, ones} !== 8'h00 || done !== 1'b1 || tick_en !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_terminal got %h done=%b te=%b want 00 1 0",
               {tens, ones}, done, tick_en);
    end
  endtask

  task automatic test_borrow();
    do_load(8'h20);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL br_load_exit got done=%b want 0", done);
    end
    do_start();
    do_tick();
    n_checks++;
    if ({tens, ones} !== 8'h19) begin
      n_fail++;
      $display("FAIL br_borrow got %h want 19", {tens, ones});
    end
    do_load(8'h01);
    do_start();
    do_tick();
    n_checks++;
    if ({tens, ones} !== 8'h00 || expired !== 1'b1) begin
      n_fail++;
      $display("FAIL br_last got %h exp=%b want 00 1",
               {tens, ones}, expired);
    end
  endtask

  task automatic test_pause_resume();
    do_load(8'h30);
    do_start();
    for (int i = 0; i < 3; i++) begin
      idle(2);
      do_tick();
    end
    n_checks++;
    if ({tens, ones} !== 8'h27) begin
      n_fail++;
      $display("FAIL pr_run got %h want 27", {tens, ones});
    end
    do_pause();
    n_checks++;
    if (tick_en !== 1'b0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL pr_pause got te=%b run=%b want 0 0",
               tick_en, running);
    end
    for (int i = 0; i < 5; i++) begin
      idle(2);
      do_tick();
    end
    n_checks++;
    if ({tens, ones} !== 8'h27 || tick_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pr_hold got %h te=%b want 27 0",
               {tens, ones}, tick_en);
    end
    do_start();
    n_checks++;
    if (tick_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pr_resume got te=%b want 1", tick_en);
    end
    do_tick();
    n_checks++;
    if ({tens, ones} !== 8'h26) begin
      n_fail++;
      $display("FAIL pr_after got %h want 26", {tens, ones});
    end
  endtask

  task automatic test_simultaneous();
    do_load(8'h12);
    do_start();
    load = 1'b1;
    load_val = 8'h45;
    one_sec_tick = 1'b1;
    step();
    load = 1'b0;
    one_sec_tick = 1'b0;
    n_checks++;
    if ({tens, ones} !== 8'h45 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_load_tick got %h run=%b want 45 0",
               {tens, ones}, running);
    end
    do_start();
    pause = 1'b1;
    one_sec_tick = 1'b1;
    step();
    pause = 1'b0;
    one_sec_tick = 1'b0;
    n_checks++;
    if ({tens, ones} !== 8'h45 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_pause_tick got %h run=%b want 45 0",
               {tens, ones}, running);
    end
    start = 1'b1;
    one_sec_tick = 1'b1;
    step();
    start = 1'b0;
    one_sec_tick = 1'b0;
    n_checks++;
    if ({tens, ones} !== 8'h45 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_resume_tick got %h run=%b want 45 1",
               {tens, ones}, running);
    end
  endtask

  task automatic test_edges();
    do_load(8'h05);
    n_checks++;
    if (warn !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_warn_idle got %b want 1", warn);
    end
    do_load(8'h00);
    do_start();
    n_checks++;
    if ({expired, done, tick_en, warn} !== 4'b1100) begin
      n_fail++;
      $display("FAIL edge_zero_start got e/d/te/w=%b want 1100",
               {expired, done, tick_en, warn});
    end
    step();
    n_checks++;
    if (expired !== 1'b0 || tick_en !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_zero_after got exp=%b te=%b want 0 0",
               expired, tick_en);
    end
    do_load(8'hAB);
    n_checks++;
    if ({tens, ones} !== 8'h99 || warn !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_clamp got %h w=%b want 99 0",
               {tens, ones}, warn);
    end
  endtask

  task automatic test_async_reset();
    do_load(8'h33);
    do_start();
    idle(3);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (tick_en !== 1'b0 || {tens, ones} !== 8'h60) begin
      n_fail++;
      $display("FAIL ar_async got te=%b %h want 0 60",
               tick_en, {tens, ones});
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++;
    if (running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_idle got run=%b done=%b want 0 0",
               running, done);
    end
    do_start();
    do_tick();
    n_checks++;
    if ({tens, ones} !== 8'h59 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_restart got %h run=%b want 59 1",
               {tens, ones}, running);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause_resume();
    test_simultaneous();
    test_edges();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
